// File: rtl/alu_ops_pkg.sv
// Shared ALU op codes, FSM state encoding and default width for the execute stage.
// Used by alu_exec_unit and alu_logic_core; optional overflow flag is enabled by ALU_OVERFLOW_EN.
package alu_ops_pkg;

   localparam int NBITS_DEFAULT = 32;

   localparam logic [3:0] OP_AND     = 4'd0;
   localparam logic [3:0] OP_OR      = 4'd1;
   localparam logic [3:0] OP_NOR     = 4'd2;
   localparam logic [3:0] OP_ADD     = 4'd3;
   localparam logic [3:0] OP_SUB     = 4'd4;
   localparam logic [3:0] OP_LUI     = 4'd5;
   localparam logic [3:0] OP_SLL     = 4'd6;
   localparam logic [3:0] OP_SRL     = 4'd7;
   localparam logic [3:0] OP_ILLEGAL = 4'd9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL);
   endfunction

   function automatic logic is_illegal(input logic [3:0] op);
      return op > OP_SRL;
   endfunction

endpackage

// File: rtl/alu_logic_core.sv
// Single-cycle combinational ALU ops (AND/OR/NOR/ADD/SUB/LUI); yields 0 for any other code.
// Signed overflow detection is built only when ALU_OVERFLOW_EN is defined.
module alu_logic_core
   import alu_ops_pkg::*;
#(
   parameter int NBITS = NBITS_DEFAULT
) (
   input  logic [3:0]       op_i,
   input  logic [NBITS-1:0] a_i,
   input  logic [NBITS-1:0] b_i,
   output logic [NBITS-1:0] result_o,
   output logic             overflow_o
);

   logic [NBITS-1:0] sum;
   logic [NBITS-1:0] diff;

   assign sum  = a_i + b_i;
   assign diff = a_i - b_i;

   always_comb begin
      result_o = '0;
      case (op_i)
         OP_AND:  result_o = a_i & b_i;
         OP_OR:   result_o = a_i | b_i;
         OP_NOR:  result_o = ~(a_i | b_i);
         OP_ADD:  result_o = sum;
         OP_SUB:  result_o = diff;
         OP_LUI:  result_o = {b_i[15:0], {(NBITS-16){1'b0}}};
         default: result_o = '0;
      endcase
   end

`ifdef ALU_OVERFLOW_EN
   always_comb begin
      overflow_o = 1'b0;
      case (op_i)
         OP_ADD:  overflow_o = (a_i[NBITS-1] == b_i[NBITS-1]) && (sum[NBITS-1] != a_i[NBITS-1]);
         OP_SUB:  overflow_o = (a_i[NBITS-1] != b_i[NBITS-1]) && (diff[NBITS-1] != a_i[NBITS-1]);
         default: overflow_o = 1'b0;
      endcase
   end
`else
   assign overflow_o = 1'b0;
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus a 1-bit-per-cycle serial shifter,
// with valid/ready on both sides. Overflow flag is live only when ALU_OVERFLOW_EN is defined.
module alu_exec_unit
   import alu_ops_pkg::*;
#(
   parameter int NBITS   = NBITS_DEFAULT,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         alu_operation,
   input  logic [NBITS-1:0]   a_data,
   input  logic [NBITS-1:0]   b_data,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NBITS-1:0]   result,
   output logic               zero,
   output logic               illegal_op,
   output logic               overflow
);

   state_e             state_q, state_d;
   logic [NBITS-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               dir_right_q, dir_right_d;
   logic [NBITS-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               illegal_q, illegal_d;
   logic               overflow_q, overflow_d;

   logic [NBITS-1:0]   core_result;
   logic               core_overflow;
   logic [NBITS-1:0]   work_shifted;
   logic [NBITS-1:0]   single_result;
   logic               accept;

   alu_logic_core #(
      .NBITS (NBITS)
   ) u_core (
      .op_i       (alu_operation),
      .a_i        (a_data),
      .b_i        (b_data),
      .result_o   (core_result),
      .overflow_o (core_overflow)
   );

   assign in_ready  = (state_q == IDLE) && !reset;
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid && in_ready;

   assign work_shifted  = dir_right_q ? (work_q >> 1) : (work_q << 1);
   // A zero-length shift bypasses the serial path and completes like any single-cycle op.
   assign single_result = is_shift(alu_operation) ? b_data : core_result;

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      cnt_d       = cnt_q;
      dir_right_d = dir_right_q;
      result_d    = result_q;
      zero_d      = zero_q;
      illegal_d   = illegal_q;
      overflow_d  = overflow_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_shift(alu_operation) && (shamt != '0)) begin
                  work_d      = b_data;
                  cnt_d       = shamt;
                  dir_right_d = (alu_operation == OP_SRL);
                  state_d     = SHIFT;
               end else begin
                  result_d   = single_result;
                  zero_d     = (single_result == '0);
                  illegal_d  = is_illegal(alu_operation);
                  overflow_d = core_overflow;
                  state_d    = DONE;
               end
            end
         end
         SHIFT: begin
            work_d = work_shifted;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == SHAMT_W'(1)) begin
               result_d   = work_shifted;
               zero_d     = (work_shifted == '0);
               illegal_d  = 1'b0;
               overflow_d = 1'b0;
               state_d    = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         work_q      <= '0;
         cnt_q       <= '0;
         dir_right_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         cnt_q       <= cnt_d;
         dir_right_q <= dir_right_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
         overflow_q  <= overflow_d;
      end
   end

   assign result     = result_q;
   assign zero       = zero_q;
   assign illegal_op = illegal_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors push expectations, a monitor pops on handshake.
// Expected overflow follows ALU_OVERFLOW_EN.
module tb_alu_exec_unit;
   import alu_ops_pkg::*;

`ifdef ALU_OVERFLOW_EN
   localparam logic OVF = 1'b1;
`else
   localparam logic OVF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_operation;
   logic [31:0] a_data;
   logic [31:0] b_data;
   logic [4:0]  shamt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal_op;
   logic        overflow;

   typedef struct {
      string       nm;
      logic [31:0] res;
      logic        z;
      logic        ill;
      logic        ovf;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   stim_done = 1'b0;

   always #5 clk = ~clk;

   alu_exec_unit dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .alu_operation (alu_operation),
      .a_data        (a_data),
      .b_data        (b_data),
      .shamt         (shamt),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .result        (result),
      .zero          (zero),
      .illegal_op    (illegal_op),
      .overflow      (overflow)
   );

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
   endtask

   task automatic check1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b", nm, act, exp);
   endtask

   function automatic exp_t mk_exp(input string nm, input logic [31:0] r, input logic ill, input logic ovf);
      exp_t e;
      e.nm  = nm;
      e.res = r;
      e.z   = (r == 32'h0);
      e.ill = ill;
      e.ovf = ovf;
      return e;
   endfunction

   // Monitor: every accepted output must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check1("unexpected_out_valid", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               $display("txn %s: result=0x%08h zero=%b illegal=%b ovf=%b", e.nm, result, zero, illegal_op, overflow);
               check32({e.nm, "_result"}, result, e.res);
               check1({e.nm, "_zero"}, zero, e.z);
               check1({e.nm, "_illegal"}, illegal_op, e.ill);
               check1({e.nm, "_overflow"}, overflow, e.ovf);
            end
         end
      end
   end

   task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] er, input logic ei, input logic eo,
                        input int elat, input bit hold_valid);
      int guard;
      int lat;
      bit busy_ready;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check1({nm, "_in_ready_before"}, in_ready, 1'b1);
      alu_operation = op;
      a_data        = a;
      b_data        = b;
      shamt         = sh;
      in_valid      = 1'b1;
      exp_q.push_back(mk_exp(nm, er, ei, eo));
      @(posedge clk); #1;
      if (hold_valid) begin
         alu_operation = OP_ADD;
         a_data        = 32'h1111_1111;
         b_data        = 32'h2222_2222;
      end else begin
         in_valid = 1'b0;
      end
      check1({nm, "_in_ready_after_accept"}, in_ready, 1'b0);
      lat = 0;
      busy_ready = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready) busy_ready = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      check32({nm, "_latency"}, 32'(lat), 32'(elat));
      check1({nm, "_busy_ready"}, busy_ready, 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      bit stale;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      alu_operation = OP_AND; a_data = '0; b_data = '0; shamt = '0;
      repeat (3) @(posedge clk);
      #1;
      check1("rst_out_valid", out_valid, 1'b0);
      check1("rst_in_ready", in_ready, 1'b0);
      check32("rst_result", result, 32'h0);
      check1("rst_zero", zero, 1'b0);
      reset = 1'b0;
      #1;
      check1("rst_release_in_ready", in_ready, 1'b1);

      do_op("add_5_3",   OP_ADD, 32'h5, 32'h3, 5'd0, 32'h8, 1'b0, 1'b0, 0, 1'b0);
      do_op("sub_eq",    OP_SUB, 32'h1234_5678, 32'h1234_5678, 5'd0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
      do_op("sub_ovf",   OP_SUB, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b0, OVF, 0, 1'b0);
      do_op("add_ovf",   OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, OVF, 0, 1'b0);
      do_op("add_wrap",  OP_ADD, 32'hFFFF_FFFF, 32'h1, 5'd3, 32'h0, 1'b0, 1'b0, 0, 1'b0);
      do_op("and",       OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 32'h0F00_0F00, 1'b0, 1'b0, 0, 1'b0);
      do_op("or",        OP_OR,  32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 32'hF0F0_0F0F, 1'b0, 1'b0, 0, 1'b0);
      do_op("nor_ones",  OP_NOR, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0);
      do_op("nor_zero",  OP_NOR, 32'hFFFF_0000, 32'h0000_FFFF, 5'd0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
      do_op("lui",       OP_LUI, 32'h5555_5555, 32'h1234_ABCD, 5'd0, 32'hABCD_0000, 1'b0, 1'b0, 0, 1'b0);
      do_op("illegal9",  OP_ILLEGAL, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0, 0, 1'b0);
      do_op("illegal15", 4'd15, 32'hAAAA_AAAA, 32'h5555_5555, 5'd7, 32'h0, 1'b1, 1'b0, 0, 1'b0);
      do_op("sll_31",    OP_SLL, 32'hDEAD_BEEF, 32'h1, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 31, 1'b0);
      do_op("srl_4",     OP_SRL, 32'h0, 32'hF000_0000, 5'd4, 32'h0F00_0000, 1'b0, 1'b0, 4, 1'b1);
      do_op("sll_0",     OP_SLL, 32'h0, 32'h0000_1234, 5'd0, 32'h0000_1234, 1'b0, 1'b0, 0, 1'b0);
      do_op("srl_31",    OP_SRL, 32'h0, 32'h8000_0000, 5'd31, 32'h1, 1'b0, 1'b0, 31, 1'b0);
      do_op("sll_1",     OP_SLL, 32'h0, 32'h8000_0001, 5'd1, 32'h2, 1'b0, 1'b0, 1, 1'b0);
      do_op("srl_out",   OP_SRL, 32'h0, 32'h0000_0007, 5'd3, 32'h0, 1'b0, 1'b0, 3, 1'b0);

      // Backpressure: result held in DONE while a new op waits on in_valid.
      out_ready = 1'b0;
      alu_operation = OP_ADD; a_data = 32'h10; b_data = 32'h20; shamt = '0; in_valid = 1'b1;
      exp_q.push_back(mk_exp("bp_add", 32'h30, 1'b0, 1'b0));
      @(posedge clk); #1;
      alu_operation = OP_OR; a_data = 32'hF0; b_data = 32'h0F;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check32("bp_hold_result", result, 32'h30);
         check1("bp_hold_valid", out_valid, 1'b1);
         check1("bp_hold_ready", in_ready, 1'b0);
      end
      exp_q.push_back(mk_exp("bp_or", 32'hFF, 1'b0, 1'b0));
      out_ready = 1'b1;
      @(posedge clk); #1;
      check1("bp_release_idle_valid", out_valid, 1'b0);
      check1("bp_release_idle_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check1("bp_next_accepted", out_valid, 1'b1);
      @(posedge clk); #1;
      check32("bp_hold_after_idle", result, 32'hFF);

      // Make result/overflow nonzero, then abort a shift with reset.
      do_op("pre_rst_add", OP_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd0, 32'hFFFF_FFFE, 1'b0, OVF, 0, 1'b0);
      alu_operation = OP_SLL; a_data = 32'h0; b_data = 32'h1; shamt = 5'd10; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      check1("mid_rst_out_valid", out_valid, 1'b0);
      check32("mid_rst_result", result, 32'h0);
      check1("mid_rst_zero", zero, 1'b0);
      check1("mid_rst_overflow", overflow, 1'b0);
      check1("mid_rst_illegal", illegal_op, 1'b0);
      reset = 1'b0;
      #1;
      check1("mid_rst_in_ready", in_ready, 1'b1);
      stale = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         if (out_valid) stale = 1'b1;
      end
      check1("mid_rst_no_stale", stale, 1'b0);

      // Reset wins over a simultaneous in_valid.
      reset = 1'b1; alu_operation = OP_ADD; a_data = 32'h1; b_data = 32'h1; in_valid = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0;
      stale = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (out_valid) stale = 1'b1;
      end
      check1("rst_vs_valid_no_accept", stale, 1'b0);
      check32("rst_vs_valid_result", result, 32'h0);

      do_op("final_sub", OP_SUB, 32'h0, 32'h1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0);
      repeat (2) @(posedge clk);
      check32("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      stim_done = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      if (!stim_done) begin
         $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
         $fatal(1, "watchdog expired");
      end
   end

endmodule
